// File: rtl/lebug_pkg.sv
// Shared definitions for the vector-scalar reduce stage: op encodings, config stride,
// and chain-id width helpers.
package lebug_pkg;

    localparam logic [7:0] OP_PASS = 8'd0;
    localparam logic [7:0] OP_SUM  = 8'd1;
    localparam logic [7:0] OP_MAX  = 8'd2;
    localparam logic [7:0] OP_MIN  = 8'd3;

    // Config slots per chain: op, then acc_en.
    localparam int unsigned CFG_STRIDE = 2;

    function automatic int unsigned chain_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_MAX_CHAINS = 4;
    typedef logic [chain_w(DEF_MAX_CHAINS)-1:0] chain_id_t;

endpackage

// File: rtl/lane_reducer.sv
// Combinational cross-lane sum/max (and min when VSRU_MIN_EN is defined), plus the
// two-operand combine that folds a reduction into a running accumulator.
module lane_reducer
    import lebug_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [7:0]                   op_i,
    input  logic [N-1:0][DATA_WIDTH-1:0] vec_i,
    input  logic [DATA_WIDTH-1:0]        acc_i,
    input  logic                         acc_empty_i,
    output logic [DATA_WIDTH-1:0]        red_o,
    output logic [DATA_WIDTH-1:0]        new_o
);

    logic [DATA_WIDTH-1:0] sum, mx, comb;
`ifdef VSRU_MIN_EN
    logic [DATA_WIDTH-1:0] mn;
`endif

    always_comb begin
        sum = '0;
        mx  = '0;
`ifdef VSRU_MIN_EN
        mn  = '1;
`endif
        for (int i = 0; i < N; i++) begin
            sum = sum + vec_i[i];
            if (vec_i[i] > mx) mx = vec_i[i];
`ifdef VSRU_MIN_EN
            if (vec_i[i] < mn) mn = vec_i[i];
`endif
        end

        red_o = sum;
        comb  = acc_i + red_o;
        if (op_i == OP_MAX) begin
            red_o = mx;
            comb  = (acc_i > red_o) ? acc_i : red_o;
        end
`ifdef VSRU_MIN_EN
        if (op_i == OP_MIN) begin
            red_o = mn;
            comb  = (acc_i < red_o) ? acc_i : red_o;
        end
`endif
        new_o = acc_empty_i ? red_o : comb;
    end

endmodule

// File: rtl/vector_scalar_reduce.sv
// Two-stage vector pass/reduce stage with per-chain firmware and optional accumulation.
// Defining VSRU_MIN_EN makes op 3 an unsigned min; otherwise op 3 is passthrough.
module vector_scalar_reduce
    import lebug_pkg::*;
#(
    parameter int unsigned N                  = 8,
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned MAX_CHAINS         = 4,
    parameter int unsigned PERSONAL_CONFIG_ID = 0
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 tracing,
    input  logic                                 valid_in,
    input  logic                                 eof_in,
    input  logic [chain_w(MAX_CHAINS)-1:0]       chainId_in,
    input  logic [7:0]                           configId,
    input  logic [7:0]                           configData,
    input  logic [N-1:0][DATA_WIDTH-1:0]         vector_in,
    output logic [N-1:0][DATA_WIDTH-1:0]         vector_out,
    output logic [chain_w(MAX_CHAINS)-1:0]       chainId_out,
    output logic                                 valid_out,
    output logic                                 eof_out
);

    localparam int unsigned CW    = chain_w(MAX_CHAINS);
    localparam int unsigned SLOTS = CFG_STRIDE * MAX_CHAINS;
    localparam int unsigned PW    = chain_w(SLOTS);
    localparam logic [PW-1:0] PtrLast = PW'(SLOTS - 1);

    logic [7:0]    fw_op_q  [MAX_CHAINS];
    logic [7:0]    fw_acc_q [MAX_CHAINS];
    logic [PW-1:0] cfg_ptr_q;
    logic [CW-1:0] cfg_chain;
    logic          cfg_hit;

    assign cfg_hit   = (configId == 8'(PERSONAL_CONFIG_ID));
    assign cfg_chain = CW'(cfg_ptr_q >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ptr_q <= '0;
            for (int c = 0; c < MAX_CHAINS; c++) begin
                fw_op_q[c]  <= '0;
                fw_acc_q[c] <= '0;
            end
        end else if (cfg_hit) begin
            if (cfg_ptr_q[0]) fw_acc_q[cfg_chain] <= configData;
            else              fw_op_q[cfg_chain]  <= configData;
            cfg_ptr_q <= (cfg_ptr_q == PtrLast) ? '0 : cfg_ptr_q + PW'(1);
        end
    end

    logic [N-1:0][DATA_WIDTH-1:0] s1_vec_q;
    logic                         s1_valid_q, s1_eof_q;
    logic [CW-1:0]                s1_chain_q;
    logic [7:0]                   s1_op_q, s1_acc_en_q;

    // Firmware is read from the registered copy, so a same-cycle write is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vec_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_eof_q    <= 1'b0;
            s1_chain_q  <= '0;
            s1_op_q     <= '0;
            s1_acc_en_q <= '0;
        end else begin
            s1_valid_q <= tracing & valid_in;
            if (tracing) begin
                s1_vec_q    <= vector_in;
                s1_eof_q    <= eof_in;
                s1_chain_q  <= chainId_in;
                s1_op_q     <= fw_op_q[chainId_in];
                s1_acc_en_q <= fw_acc_q[chainId_in];
            end
        end
    end

    logic [DATA_WIDTH-1:0] acc_q [MAX_CHAINS];
    logic [DATA_WIDTH-1:0] acc_d [MAX_CHAINS];
    logic [MAX_CHAINS-1:0] acc_empty_q, acc_empty_d;
    logic [DATA_WIDTH-1:0] red, acc_new;
    logic                  is_red, acc_mode;

    lane_reducer #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_reducer (
        .op_i        (s1_op_q),
        .vec_i       (s1_vec_q),
        .acc_i       (acc_q[s1_chain_q]),
        .acc_empty_i (acc_empty_q[s1_chain_q]),
        .red_o       (red),
        .new_o       (acc_new)
    );

    always_comb begin
        is_red = (s1_op_q == OP_SUM) || (s1_op_q == OP_MAX);
`ifdef VSRU_MIN_EN
        if (s1_op_q == OP_MIN) is_red = 1'b1;
`endif
        acc_mode = is_red && (s1_acc_en_q != 8'd0);
    end

    logic [N-1:0][DATA_WIDTH-1:0] out_vec_d;
    logic [CW-1:0]                out_chain_d;
    logic                         out_valid_d, out_eof_d;

    always_comb begin
        acc_d       = acc_q;
        acc_empty_d = acc_empty_q;
        out_vec_d   = '0;
        out_chain_d = '0;
        out_valid_d = 1'b0;
        out_eof_d   = 1'b0;
        if (s1_valid_q) begin
            if (!is_red) begin
                out_vec_d   = s1_vec_q;
                out_chain_d = s1_chain_q;
                out_valid_d = 1'b1;
                out_eof_d   = s1_eof_q;
            end else if (!acc_mode) begin
                out_vec_d[0] = red;
                out_chain_d  = s1_chain_q;
                out_valid_d  = 1'b1;
                out_eof_d    = s1_eof_q;
            end else if (s1_eof_q) begin
                out_vec_d[0]            = acc_new;
                out_chain_d             = s1_chain_q;
                out_valid_d             = 1'b1;
                out_eof_d               = 1'b1;
                acc_d[s1_chain_q]       = '0;
                acc_empty_d[s1_chain_q] = 1'b1;
            end else begin
                acc_d[s1_chain_q]       = acc_new;
                acc_empty_d[s1_chain_q] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < MAX_CHAINS; c++) acc_q[c] <= '0;
            acc_empty_q <= '1;
            vector_out  <= '0;
            chainId_out <= '0;
            valid_out   <= 1'b0;
            eof_out     <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_empty_q <= acc_empty_d;
            vector_out  <= out_vec_d;
            chainId_out <= out_chain_d;
            valid_out   <= out_valid_d;
            eof_out     <= out_eof_d;
        end
    end

endmodule

// File: tb/tb_vector_scalar_reduce.sv
// Scoreboard bench for vector_scalar_reduce: directed vectors, queue of expected outputs.
module tb_vector_scalar_reduce;

    typedef logic [7:0][31:0] vec_t;
    typedef struct {
        vec_t       v;
        logic [1:0] c;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tracing = 1'b1;
    logic       valid_in = 1'b0;
    logic       eof_in = 1'b0;
    logic [1:0] chainId_in = '0;
    logic [7:0] configId = 8'hFF;
    logic [7:0] configData = '0;
    vec_t       vector_in = '0;
    vec_t       vector_out;
    logic [1:0] chainId_out;
    logic       valid_out;
    logic       eof_out;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    vector_scalar_reduce #(
        .N                  (8),
        .DATA_WIDTH         (32),
        .MAX_CHAINS         (4),
        .PERSONAL_CONFIG_ID (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tracing     (tracing),
        .valid_in    (valid_in),
        .eof_in      (eof_in),
        .chainId_in  (chainId_in),
        .configId    (configId),
        .configData  (configData),
        .vector_in   (vector_in),
        .vector_out  (vector_out),
        .chainId_out (chainId_out),
        .valid_out   (valid_out),
        .eof_out     (eof_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every valid output must match the oldest expected record.
    always @(negedge clk) begin
        if (rst_n && valid_out) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got vec=%h chain=%0d eof=%0b, none expected",
                         vector_out, chainId_out, eof_out);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                if (vector_out !== x.v || chainId_out !== x.c || eof_out !== x.e) begin
                    errors++;
                    $display("FAIL output got vec=%h chain=%0d eof=%0b exp vec=%h chain=%0d eof=%0b",
                             vector_out, chainId_out, eof_out, x.v, x.c, x.e);
                end
            end
        end
    end

    function automatic vec_t fill(input logic [31:0] val);
        vec_t v;
        for (int j = 0; j < 8; j++) v[j] = val;
        return v;
    endfunction

    function automatic vec_t seq_vec(input logic [31:0] base);
        vec_t v;
        for (int j = 0; j < 8; j++) v[j] = base + 32'(j);
        return v;
    endfunction

    function automatic vec_t one_hot(input logic [31:0] val, input int pos, input logic [31:0] big);
        vec_t v;
        v = fill(val);
        v[pos] = big;
        return v;
    endfunction

    function automatic vec_t red_vec(input logic [31:0] r);
        vec_t v;
        v = '0;
        v[0] = r;
        return v;
    endfunction

    task automatic expect_out(input vec_t v, input logic [1:0] c, input logic e);
        exp_t x;
        x.v = v;
        x.c = c;
        x.e = e;
        exp_q.push_back(x);
    endtask

    task automatic cfg_byte(input logic [7:0] b);
        configId   = 8'd0;
        configData = b;
        @(posedge clk);
        #1;
        configId   = 8'hFF;
    endtask

    task automatic program_fw(input logic [7:0] o0, input logic [7:0] a0,
                              input logic [7:0] o1, input logic [7:0] a1,
                              input logic [7:0] o2, input logic [7:0] a2,
                              input logic [7:0] o3, input logic [7:0] a3);
        cfg_byte(o0); cfg_byte(a0); cfg_byte(o1); cfg_byte(a1);
        cfg_byte(o2); cfg_byte(a2); cfg_byte(o3); cfg_byte(a3);
    endtask

    task automatic send(input logic [1:0] c, input logic e, input vec_t v);
        valid_in   = 1'b1;
        chainId_in = c;
        eof_in     = e;
        vector_in  = v;
        @(posedge clk);
        #1;
        valid_in   = 1'b0;
        eof_in     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if (vector_out !== '0 || chainId_out !== '0 || valid_out !== 1'b0 || eof_out !== 1'b0) begin
            errors++;
            $display("FAIL %s got vec=%h chain=%0d valid=%0b eof=%0b exp all zero",
                     name, vector_out, chainId_out, valid_out, eof_out);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0b exp %0b", name, got, exp);
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_zero_outputs("reset_outputs");
        rst_n = 1'b1;
        idle(1);

        // Non-accumulating sum with latency check
        program_fw(8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0);
        expect_out(red_vec(32'd36), 2'd0, 1'b1);
        send(2'd0, 1'b1, seq_vec(32'd1));
        @(negedge clk);
        check_bit("latency_s1_no_output", valid_out, 1'b0);
        @(negedge clk);
        check_bit("latency_s2_output", valid_out, 1'b1);
        idle(2);

        // Max accumulation on chain1, back-to-back
        expect_out(red_vec(32'd9), 2'd1, 1'b1);
        send(2'd1, 1'b0, one_hot(32'd1, 2, 32'd5));
        send(2'd1, 1'b0, one_hot(32'd2, 6, 32'd9));
        send(2'd1, 1'b1, one_hot(32'd0, 0, 32'd3));
        idle(3);

        // Interleaved chains, both accumulating: 8+36+16=60, max(7,20,4)=20
        program_fw(8'd1, 8'd1, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0);
        expect_out(red_vec(32'd60), 2'd0, 1'b1);
        expect_out(red_vec(32'd20), 2'd1, 1'b1);
        send(2'd0, 1'b0, fill(32'd1));
        send(2'd1, 1'b0, one_hot(32'd3, 4, 32'd7));
        send(2'd0, 1'b0, seq_vec(32'd1));
        send(2'd1, 1'b0, one_hot(32'd0, 7, 32'd20));
        send(2'd0, 1'b1, fill(32'd2));
        send(2'd1, 1'b1, fill(32'd4));
        idle(3);

        // Firmware written in the same cycle a vector enters does not apply to it
        cfg_byte(8'd1); cfg_byte(8'd0); cfg_byte(8'd2); cfg_byte(8'd1);
        cfg_byte(8'd2); cfg_byte(8'd0);
        expect_out(seq_vec(32'd100), 2'd3, 1'b0);
        expect_out(red_vec(32'd36), 2'd3, 1'b0);
        configId   = 8'd0;
        configData = 8'd1;
        valid_in   = 1'b1;
        chainId_in = 2'd3;
        eof_in     = 1'b0;
        vector_in  = seq_vec(32'd100);
        @(posedge clk);
        #1;
        configData = 8'd0;
        vector_in  = seq_vec(32'd1);
        @(posedge clk);
        #1;
        configId   = 8'hFF;
        valid_in   = 1'b0;
        idle(3);

        // Overflow, unsigned max, empty-accumulator eof, op 3
        program_fw(8'd1, 8'd0, 8'd2, 8'd1, 8'd2, 8'd0, 8'd3, 8'd0);
        expect_out(red_vec(32'hFFFF_FFF8), 2'd0, 1'b0);
        send(2'd0, 1'b0, fill(32'hFFFF_FFFF));
        expect_out(red_vec(32'h8000_0000), 2'd2, 1'b1);
        send(2'd2, 1'b1, one_hot(32'd7, 3, 32'h8000_0000));
        expect_out(red_vec(32'd11), 2'd1, 1'b1);
        send(2'd1, 1'b1, one_hot(32'd2, 5, 32'd11));
`ifdef VSRU_MIN_EN
        expect_out(red_vec(32'd10), 2'd3, 1'b0);
`else
        expect_out(seq_vec(32'd10), 2'd3, 1'b0);
`endif
        send(2'd3, 1'b0, seq_vec(32'd10));
        idle(3);

        // Reset mid-frame drops partial accumulation
        program_fw(8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        send(2'd0, 1'b0, fill(32'd5));
        send(2'd0, 1'b0, fill(32'd5));
        rst_n = 1'b0;
        @(negedge clk);
        check_zero_outputs("mid_reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_zero_outputs("post_reset_outputs");
        program_fw(8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        expect_out(red_vec(32'd8), 2'd0, 1'b1);
        send(2'd0, 1'b1, fill(32'd1));
        idle(3);

        // Passthrough with tracing low for vectors 3..5
        program_fw(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 8; i++) begin
            vec_t v;
            for (int j = 0; j < 8; j++) v[j] = 32'hA500_0000 + 32'(i) * 32'h0101_0101 + 32'(j) * 32'h10;
            tracing    = !(i >= 3 && i <= 5);
            valid_in   = 1'b1;
            chainId_in = 2'd0;
            eof_in     = (i == 7);
            vector_in  = v;
            if (tracing) expect_out(v, 2'd0, eof_in);
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        eof_in   = 1'b0;
        tracing  = 1'b1;
        idle(4);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_outputs got %0d pending exp 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
